// File: rtl/operand_deserializer.sv
// Serial-to-parallel operand loader feeding the adder_tree operand port.
// Define OPERAND_DESER_DOUBLE_BUF_EN to add a fill bank behind the output bank.
module operand_deserializer #(
    parameter int DATA_WID = 16,
    parameter int LANE_NUM = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic signed [DATA_WID-1:0] in_data,
    input  logic                       in_valid,
    input  logic                       in_last,
    output logic                       in_ready,
    output logic signed [DATA_WID-1:0] out_vec [0:LANE_NUM-1],
    output logic [LANE_NUM-1:0]        out_mask,
    output logic                       out_valid,
    input  logic                       out_ready
);

    localparam int IDX_W = $clog2(LANE_NUM);

    logic [IDX_W-1:0] wr_idx;
    logic             accept;
    logic             complete;

    assign accept   = in_valid && in_ready;
    assign complete = accept && (in_last || (wr_idx == IDX_W'(LANE_NUM - 1)));

`ifdef OPERAND_DESER_DOUBLE_BUF_EN

    logic signed [DATA_WID-1:0] fill_vec    [0:LANE_NUM-1];
    logic signed [DATA_WID-1:0] merged_vec  [0:LANE_NUM-1];
    logic [LANE_NUM-1:0]        fill_mask;
    logic [LANE_NUM-1:0]        merged_mask;
    logic                       fill_full;

    // fill_full can only be set while the output bank is occupied
    assign in_ready = rst_n && !fill_full;

    always_comb begin
        merged_vec          = fill_vec;
        merged_mask         = fill_mask;
        merged_vec[wr_idx]  = in_data;
        merged_mask[wr_idx] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_idx    <= '0;
            fill_full <= 1'b0;
            fill_mask <= '0;
            out_mask  <= '0;
            out_valid <= 1'b0;
            for (int unsigned i = 0; i < LANE_NUM; i++) begin
                fill_vec[i] <= '0;
                out_vec[i]  <= '0;
            end
        end else begin
            if (accept && !complete) begin
                fill_vec  <= merged_vec;
                fill_mask <= merged_mask;
                wr_idx    <= wr_idx + IDX_W'(1);
            end
            if (complete) begin
                wr_idx <= '0;
                if (!out_valid || out_ready) begin
                    out_vec   <= merged_vec;
                    out_mask  <= merged_mask;
                    out_valid <= 1'b1;
                    fill_vec  <= '{default: '0};
                    fill_mask <= '0;
                end else begin
                    fill_vec  <= merged_vec;
                    fill_mask <= merged_mask;
                    fill_full <= 1'b1;
                end
            end else if (out_valid && out_ready) begin
                if (fill_full) begin
                    out_vec   <= fill_vec;
                    out_mask  <= fill_mask;
                    fill_full <= 1'b0;
                    fill_vec  <= '{default: '0};
                    fill_mask <= '0;
                end else begin
                    out_valid <= 1'b0;
                end
            end
        end
    end

`else

    typedef enum logic {FILL, HOLD} state_t;
    state_t state;

    assign in_ready = rst_n && (state == FILL);

    // Words land directly in the output bank; it is zeroed on drain so
    // unwritten lanes of a short vector are already 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= FILL;
            wr_idx    <= '0;
            out_mask  <= '0;
            out_valid <= 1'b0;
            for (int unsigned i = 0; i < LANE_NUM; i++) begin
                out_vec[i] <= '0;
            end
        end else begin
            case (state)
                FILL: begin
                    if (accept) begin
                        out_vec[wr_idx]  <= in_data;
                        out_mask[wr_idx] <= 1'b1;
                        if (complete) begin
                            wr_idx    <= '0;
                            out_valid <= 1'b1;
                            state     <= HOLD;
                        end else begin
                            wr_idx <= wr_idx + IDX_W'(1);
                        end
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        out_mask  <= '0;
                        out_vec   <= '{default: '0};
                        state     <= FILL;
                    end
                end
                default: state <= FILL;
            endcase
        end
    end

`endif

endmodule

// File: tb/tb_operand_deserializer.sv
// Self-checking bench for operand_deserializer: vector table, directed corners,
// random stream against a queue-based model of vector formation.
module tb_operand_deserializer;

    localparam int W = 16;
    localparam int L = 8;
`ifdef OPERAND_DESER_DOUBLE_BUF_EN
    localparam int CAP = 2;
`else
    localparam int CAP = 1;
`endif

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic signed [W-1:0] in_data = '0;
    logic                in_valid = 1'b0;
    logic                in_last = 1'b0;
    logic                in_ready;
    logic signed [W-1:0] dut_vec [0:L-1];
    logic [L-1:0]        out_mask;
    logic                out_valid;
    logic                out_ready = 1'b0;

    operand_deserializer #(.DATA_WID(W), .LANE_NUM(L)) dut (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
        .in_last(in_last), .in_ready(in_ready), .out_vec(dut_vec),
        .out_mask(out_mask), .out_valid(out_valid), .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end
    endtask

    function automatic logic [127:0] pack_out();
        logic [127:0] r;
        for (int i = 0; i < L; i++) r[i*W +: W] = dut_vec[i];
        return r;
    endfunction

    function automatic int tree_sum();
        int s = 0;
        for (int i = 0; i < L; i++) s += int'(dut_vec[i]);
        return s;
    endfunction

    // Reference model: expected vectors in delivery order
    typedef struct {
        logic [127:0] v;
        logic [L-1:0] m;
    } exp_t;
    exp_t        expq[$];
    logic [W-1:0] cur [0:L-1];
    int          cur_n = 0;
    time         drain_times[$];

    always @(negedge clk) begin
        if (!rst_n) begin
            cur_n = 0;
            expq.delete();
        end else begin
            exp_t e;
            chk("in_ready", in_ready, expq.size() < CAP);
            chk("out_valid", out_valid, expq.size() != 0);
            if (out_valid && out_ready && expq.size() != 0) begin
                e = expq.pop_front();
                chk("drain_vec", pack_out(), e.v);
                chk("drain_mask", out_mask, e.m);
                drain_times.push_back($time);
            end
            if (in_valid && in_ready) begin
                cur[cur_n] = in_data;
                cur_n++;
                if (in_last || cur_n == L) begin
                    e.v = '0;
                    e.m = '0;
                    for (int i = 0; i < cur_n; i++) begin
                        e.v[i*W +: W] = cur[i];
                        e.m[i] = 1'b1;
                    end
                    expq.push_back(e);
                    cur_n = 0;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_word(input logic [W-1:0] d, input logic l);
        int n = 0;
        in_data  = d;
        in_last  = l;
        in_valid = 1'b1;
        while (!in_ready && n < 50) begin
            tick();
            n++;
        end
        if (n >= 50) chk("ready_timeout", n, 0);
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    typedef struct {
        int           n;
        logic [W-1:0] w [0:L-1];
        logic         last;
        logic [L-1:0] mask;
        int           sum;
    } vrec_t;
    vrec_t tbl [5];

    initial begin
        logic [127:0] ev;
        int n;
        int s0;

        tbl[0] = '{8, '{16'h0001, 16'h00aa, 16'h00aa, 16'h00aa, 16'h00aa, 16'h00aa, 16'h00aa, 16'h00aa}, 1'b0, 8'hff, 32'h04a7};
        tbl[1] = '{3, '{16'h00aa, 16'hffaa, 16'h0008, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0}, 1'b1, 8'h07, 32'h005c};
        tbl[2] = '{8, '{16'h7fff, 16'h8000, 16'h0001, 16'h0002, 16'h0003, 16'h0004, 16'h0005, 16'hfffe}, 1'b1, 8'hff, 12};
        tbl[3] = '{1, '{16'h1234, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0}, 1'b1, 8'h01, 32'h1234};
        tbl[4] = '{4, '{16'hffff, 16'hffff, 16'hffff, 16'hffff, 16'h0, 16'h0, 16'h0, 16'h0}, 1'b1, 8'h0f, -4};

        // Reset state
        repeat (3) tick();
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_mask", out_mask, 0);
        chk("rst_out_vec", pack_out(), 0);
        #3 rst_n = 1'b1;
        #1 chk("rel_in_ready", in_ready, 1);

        // Vector table
        for (int r = 0; r < 5; r++) begin
            out_ready = 1'b0;
            for (int i = 0; i < tbl[r].n; i++)
                send_word(tbl[r].w[i], (i == tbl[r].n - 1) ? tbl[r].last : 1'b0);
            ev = '0;
            for (int i = 0; i < tbl[r].n; i++) ev[i*W +: W] = tbl[r].w[i];
            chk($sformatf("tbl%0d_valid", r), out_valid, 1);
            chk($sformatf("tbl%0d_vec", r), pack_out(), ev);
            chk($sformatf("tbl%0d_mask", r), out_mask, tbl[r].mask);
            chk($sformatf("tbl%0d_sum", r), 32'(tree_sum()), 32'(tbl[r].sum));
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
            chk($sformatf("tbl%0d_after", r), out_valid, 0);
        end

        // Backpressure with 0x6544 in lane 4
        ev = '0;
        for (int i = 0; i < L; i++) begin
            ev[i*W +: W] = (i == 4) ? 16'h6544 : 16'(i + 16'h0030);
            send_word(ev[i*W +: W], 1'b0);
        end
        for (int c = 0; c < 5; c++) begin
            chk("bp_valid", out_valid, 1);
            chk("bp_vec", pack_out(), ev);
            chk("bp_in_ready", in_ready, CAP - 1);
            tick();
        end
        s0 = drain_times.size();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("bp_one_handshake", drain_times.size() - s0, 1);
        chk("bp_ready_back", in_ready, 1);
        chk("bp_valid_low", out_valid, 0);

        // Reset mid-fill
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) send_word(16'hdead, 1'b0);
        #3 rst_n = 1'b0;
        #1;
        chk("mrst_out_valid", out_valid, 0);
        chk("mrst_out_mask", out_mask, 0);
        chk("mrst_in_ready", in_ready, 0);
        @(negedge clk);
        @(posedge clk);
        #2 rst_n = 1'b1;
        #1 chk("mrst_rel_ready", in_ready, 1);
        out_ready = 1'b0;
        ev = '0;
        for (int i = 0; i < L; i++) begin
            ev[i*W +: W] = 16'(16'h0100 + i);
            send_word(ev[i*W +: W], 1'b0);
        end
        chk("mrst_vec", pack_out(), ev);
        chk("mrst_mask", out_mask, 8'hff);
        out_ready = 1'b1;
        tick();

`ifdef OPERAND_DESER_DOUBLE_BUF_EN
        // Continuous stream: three vectors, no idle cycle
        s0 = drain_times.size();
        for (int i = 0; i < 24; i++) begin
            in_valid = 1'b1;
            in_data  = 16'(i * 3 + 1);
            chk("db_stream_ready", in_ready, 1);
            tick();
        end
        in_valid = 1'b0;
        repeat (3) tick();
        chk("db_vec_count", drain_times.size() - s0, 3);
        if (drain_times.size() - s0 >= 3) begin
            chk("db_interval1", 64'(drain_times[s0+1] - drain_times[s0]), 80);
            chk("db_interval2", 64'(drain_times[s0+2] - drain_times[s0+1]), 80);
        end
        // Both banks fill under backpressure
        out_ready = 1'b0;
        in_valid  = 1'b1;
        n = 0;
        while (in_ready && n < 40) begin
            in_data = 16'($urandom);
            tick();
            n++;
        end
        in_valid = 1'b0;
        chk("db_accepts_to_full", n, 16);
        out_ready = 1'b1;
        repeat (4) tick();
`endif

        // Random stream
        for (int c = 0; c < 600; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_data   = 16'($urandom);
            in_last   = ($urandom_range(0, 6) == 0);
            out_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        send_word(16'h5a5a, 1'b1);
        out_ready = 1'b1;
        n = 0;
        while (expq.size() != 0 && n < 100) begin
            tick();
            n++;
        end
        chk("all_delivered", expq.size(), 0);
        repeat (2) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "watchdog");
    end

endmodule
